// File: rtl/pl_stage_skid_if.sv
// Valid/ready beat channel carrying a control vector and a datapath payload.
// The master drives valid/ctrl/data; the slave drives ready.
interface pl_stage_skid_if #(
    parameter int DW = 32,
    parameter int CW = 8
);
    logic          valid;
    logic          ready;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;

    modport master (output valid, ctrl, data, input ready);
    modport slave  (input valid, ctrl, data, output ready);
endinterface

// File: rtl/pl_stage_skid.sv
// Elastic pipeline-stage register: main entry drives the output, a skid entry
// absorbs the one beat in flight when downstream stalls. Flush squashes or drops.
module pl_stage_skid #(
    parameter int DW         = 32,
    parameter int CW         = 8,
    parameter int FLUSH_MODE = 0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    pl_stage_skid_if.slave    up,
    pl_stage_skid_if.master   dn,
    output logic [1:0]        occupancy
);
    logic          m_v, s_v, n_mv, n_sv;
    logic [CW-1:0] m_c, s_c, n_mc, n_sc;
    logic [DW-1:0] m_d, s_d, n_md, n_sd;
    logic          acc, pop;

    // in_ready depends only on registered state and flush, breaking the ready path
    assign up.ready = !s_v && !flush;
    assign dn.valid = m_v && !flush;
    assign dn.ctrl  = m_c;
    assign dn.data  = m_d;

    assign acc = up.valid && up.ready;
    assign pop = dn.valid && dn.ready;

    always_comb begin
        n_mv = m_v;
        n_mc = m_c;
        n_md = m_d;
        n_sv = s_v;
        n_sc = s_c;
        n_sd = s_d;
        if (flush) begin
            if (FLUSH_MODE == 0) begin
                n_mc = '0;
                n_sc = '0;
            end else begin
                n_mv = 1'b0;
                n_sv = 1'b0;
            end
        end else if (pop) begin
            if (s_v) begin
                n_mc = s_c;
                n_md = s_d;
                n_sv = 1'b0;
            end else if (acc) begin
                n_mc = up.ctrl;
                n_md = up.data;
            end else begin
                n_mv = 1'b0;
            end
        end else if (acc) begin
            if (!m_v) begin
                n_mv = 1'b1;
                n_mc = up.ctrl;
                n_md = up.data;
            end else begin
                n_sv = 1'b1;
                n_sc = up.ctrl;
                n_sd = up.data;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_v       <= 1'b0;
            m_c       <= '0;
            m_d       <= '0;
            s_v       <= 1'b0;
            s_c       <= '0;
            s_d       <= '0;
            occupancy <= 2'd0;
        end else begin
            m_v       <= n_mv;
            m_c       <= n_mc;
            m_d       <= n_md;
            s_v       <= n_sv;
            s_c       <= n_sc;
            s_d       <= n_sd;
            occupancy <= {1'b0, n_mv} + {1'b0, n_sv};
        end
    end

    // Skid is only ever filled behind a valid main entry
    a_skid_implies_main: assert property (@(posedge CLK) disable iff (!nRST)
        !(s_v && !m_v));

    a_data_stable: assert property (@(posedge CLK) disable iff (!nRST)
        (dn.valid && !dn.ready) |=> $stable(dn.data));
endmodule

// File: tb/tb_pl_stage_skid.sv
// Drives a squash-mode and a drop-mode stage with shared stimulus; checks
// vector tables, flush/reset sequences and a queue scoreboard under random traffic.
module tb_pl_stage_skid;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        fl = 1'b0;
    logic        iv = 1'b0;
    logic        ordy = 1'b0;
    logic [7:0]  ic = '0;
    logic [31:0] id = '0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    pl_stage_skid_if #(.DW(32), .CW(8)) up0 ();
    pl_stage_skid_if #(.DW(32), .CW(8)) dn0 ();
    pl_stage_skid_if #(.DW(32), .CW(8)) up1 ();
    pl_stage_skid_if #(.DW(32), .CW(8)) dn1 ();
    logic [1:0] occ0, occ1;

    assign up0.valid = iv;
    assign up0.ctrl  = ic;
    assign up0.data  = id;
    assign dn0.ready = ordy;
    assign up1.valid = iv;
    assign up1.ctrl  = ic;
    assign up1.data  = id;
    assign dn1.ready = ordy;

    pl_stage_skid #(.DW(32), .CW(8), .FLUSH_MODE(0)) u0 (
        .CLK(clk), .nRST(nrst), .flush(fl), .up(up0), .dn(dn0), .occupancy(occ0));
    pl_stage_skid #(.DW(32), .CW(8), .FLUSH_MODE(1)) u1 (
        .CLK(clk), .nRST(nrst), .flush(fl), .up(up1), .dn(dn1), .occupancy(occ1));

    logic        ov [2];
    logic        ir [2];
    logic [1:0]  oq [2];
    logic [7:0]  oc [2];
    logic [31:0] od [2];
    assign ov[0] = dn0.valid;
    assign ov[1] = dn1.valid;
    assign ir[0] = up0.ready;
    assign ir[1] = up1.ready;
    assign oq[0] = occ0;
    assign oq[1] = occ1;
    assign oc[0] = dn0.ctrl;
    assign oc[1] = dn1.ctrl;
    assign od[0] = dn0.data;
    assign od[1] = dn1.data;

    typedef struct packed {
        logic [7:0]  c;
        logic [31:0] d;
    } ent_t;
    ent_t q0[$];
    ent_t q1[$];

    typedef struct {
        logic        iv;
        logic        ordy;
        logic [7:0]  c;
        logic [31:0] d;
        logic        e_ov;
        logic [7:0]  e_c;
        logic [31:0] e_d;
        logic [1:0]  e_occ;
        logic        e_ir;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Outputs of one DUT against expected values; ctrl/data only checked when valid
    task automatic chk_dut(input string nm, input int m, input logic e_ov, input logic [7:0] e_c,
                           input logic [31:0] e_d, input logic [1:0] e_occ, input logic e_ir);
        chk($sformatf("%s u%0d out_valid", nm, m), 32'(ov[m]), 32'(e_ov));
        chk($sformatf("%s u%0d occupancy", nm, m), 32'(oq[m]), 32'(e_occ));
        chk($sformatf("%s u%0d in_ready", nm, m), 32'(ir[m]), 32'(e_ir));
        if (e_ov) begin
            chk($sformatf("%s u%0d out_ctrl", nm, m), 32'(oc[m]), 32'(e_c));
            chk($sformatf("%s u%0d out_data", nm, m), od[m], e_d);
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic f,
                         input logic [7:0] c, input logic [31:0] d);
        @(negedge clk);
        iv = v; ordy = r; fl = f; ic = c; id = d;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0; iv = 1'b1; id = 32'hDEAD; ic = 8'h5A; ordy = 1'b1; fl = 1'b0;
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk_dut("reset", m, 1'b0, 8'h0, 32'h0, 2'd0, 1'b1);
            chk($sformatf("reset u%0d out_data", m), od[m], 32'h0);
            chk($sformatf("reset u%0d out_ctrl", m), 32'(oc[m]), 32'h0);
        end
        @(negedge clk);
        nrst = 1'b1; iv = 1'b0; ordy = 1'b0; id = '0; ic = '0;
    endtask

    function automatic vec_t mk(input logic v, input logic r, input logic [31:0] d,
                                input logic e_ov, input logic [31:0] e_d,
                                input logic [1:0] e_occ, input logic e_ir);
        vec_t t;
        t.iv = v; t.ordy = r; t.c = 8'h10 + d[7:0]; t.d = d;
        t.e_ov = e_ov; t.e_c = 8'h10 + e_d[7:0]; t.e_d = e_d;
        t.e_occ = e_occ; t.e_ir = e_ir;
        return t;
    endfunction

    task automatic model_step(input int m);
        ent_t q[$];
        logic eir, eov;
        if (m == 0) q = q0; else q = q1;
        eir = (q.size() < 2) && !fl;
        eov = (q.size() > 0) && !fl;
        chk($sformatf("rnd u%0d in_ready", m), 32'(ir[m]), 32'(eir));
        chk($sformatf("rnd u%0d out_valid", m), 32'(ov[m]), 32'(eov));
        chk($sformatf("rnd u%0d occupancy", m), 32'(oq[m]), q.size());
        if (eov) begin
            chk($sformatf("rnd u%0d out_ctrl", m), 32'(oc[m]), 32'(q[0].c));
            chk($sformatf("rnd u%0d out_data", m), od[m], q[0].d);
        end
        if (fl) begin
            if (m == 0) foreach (q[i]) q[i].c = '0;
            else q.delete();
        end else begin
            if (eov && ordy) void'(q.pop_front());
            if (iv && eir) q.push_back({ic, id});
        end
        if (m == 0) q0 = q; else q1 = q;
    endtask

    initial begin
        // Stream 1..8 at full rate, then a two-beat back-pressure burst
        tbl[0]  = mk(1, 1, 1,  0, 0, 0, 1);
        tbl[1]  = mk(1, 1, 2,  1, 1, 1, 1);
        tbl[2]  = mk(1, 1, 3,  1, 2, 1, 1);
        tbl[3]  = mk(1, 1, 4,  1, 3, 1, 1);
        tbl[4]  = mk(1, 1, 5,  1, 4, 1, 1);
        tbl[5]  = mk(1, 1, 6,  1, 5, 1, 1);
        tbl[6]  = mk(1, 1, 7,  1, 6, 1, 1);
        tbl[7]  = mk(1, 1, 8,  1, 7, 1, 1);
        tbl[8]  = mk(0, 1, 0,  1, 8, 1, 1);
        tbl[9]  = mk(0, 1, 0,  0, 0, 0, 1);
        tbl[10] = mk(1, 0, 10, 0, 0, 0, 1);
        tbl[11] = mk(1, 0, 11, 1, 10, 1, 1);
        tbl[12] = mk(0, 0, 0,  1, 10, 2, 0);
        tbl[13] = mk(0, 1, 0,  1, 10, 2, 0);
        tbl[14] = mk(0, 1, 0,  1, 11, 1, 1);
        tbl[15] = mk(0, 1, 0,  0, 0, 0, 1);

        iv = 1'b1; id = 32'hDEAD;
        do_reset();

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].iv, tbl[i].ordy, 1'b0, tbl[i].c, tbl[i].d);
            for (int m = 0; m < 2; m++)
                chk_dut($sformatf("tbl[%0d]", i), m, tbl[i].e_ov, tbl[i].e_c, tbl[i].e_d,
                        tbl[i].e_occ, tbl[i].e_ir);
        end

        // Single held beat, one flush pulse
        do_reset();
        drive(1, 0, 0, 8'hFF, 32'h55);
        drive(0, 0, 1, 8'h00, 32'h0);
        for (int m = 0; m < 2; m++)
            chk_dut("flush1 during", m, 1'b0, 8'h0, 32'h0, 2'd1, 1'b0);
        drive(0, 0, 0, 8'h00, 32'h0);
        chk_dut("flush1 after", 0, 1'b1, 8'h00, 32'h55, 2'd1, 1'b1);
        chk_dut("flush1 after", 1, 1'b0, 8'h00, 32'h0, 2'd0, 1'b1);

        // Full stage, flush with an incoming beat that must not be taken
        do_reset();
        drive(1, 0, 0, 8'h01, 32'hA1);
        drive(1, 0, 0, 8'h02, 32'hA2);
        drive(0, 0, 0, 8'h00, 32'h0);
        for (int m = 0; m < 2; m++)
            chk_dut("flush2 full", m, 1'b1, 8'h01, 32'hA1, 2'd2, 1'b0);
        drive(1, 0, 1, 8'h03, 32'hA3);
        for (int m = 0; m < 2; m++)
            chk_dut("flush2 during", m, 1'b0, 8'h0, 32'h0, 2'd2, 1'b0);
        drive(0, 0, 0, 8'h00, 32'h0);
        chk_dut("flush2 after", 0, 1'b1, 8'h00, 32'hA1, 2'd2, 1'b0);
        chk_dut("flush2 after", 1, 1'b0, 8'h00, 32'h0, 2'd0, 1'b1);
        drive(0, 1, 0, 8'h00, 32'h0);
        chk_dut("flush2 drain0", 0, 1'b1, 8'h00, 32'hA1, 2'd2, 1'b0);
        drive(0, 1, 0, 8'h00, 32'h0);
        chk_dut("flush2 drain1", 0, 1'b1, 8'h00, 32'hA2, 2'd1, 1'b1);
        drive(0, 1, 0, 8'h00, 32'h0);
        chk_dut("flush2 drain2", 0, 1'b0, 8'h00, 32'h0, 2'd0, 1'b1);

        // Reset while both entries are held
        drive(1, 0, 0, 8'h07, 32'hB1);
        drive(1, 0, 0, 8'h08, 32'hB2);
        do_reset();

        // Random traffic against the queue scoreboard
        q0.delete();
        q1.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            iv   = ($urandom_range(99) < 30);
            ordy = ($urandom_range(99) < 30);
            fl   = ($urandom_range(99) < 30);
            ic   = 8'($urandom);
            id   = $urandom;
            #1;
            model_step(0);
            model_step(1);
        end

        @(negedge clk);
        iv = 1'b0; fl = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
